uart_cmd_scheduler: RTL
=======================

UART_CMD_SCHEDULER -- requirements
Module: uart_cmd_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART/RF data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 SHALL have ports, in this order:
- CLK  in  1  single clock.
- RST  in  1  reset; asynchronous, active-low.
- RX_P_DATA  in  DATA_WIDTH  received frame byte.
- RX_D_VLD  in  1  one-cycle pulse per good frame.
- RdData  in  DATA_WIDTH  register-file read data.
- RdData_Valid  in  1  read data valid.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- ALU_OUT_VLD  in  1  ALU result valid.
- FIFO_FULL  in  1  TX FIFO full.
- WrEn  out  1  RF write strobe.
- RdEn  out  1  RF read strobe.
- Address  out  ADDR_WIDTH  RF address.
- WrData  out  DATA_WIDTH  RF write data.
- ALU_EN  out  1  ALU start.
- ALU_FUN  out  4  ALU function.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  DATA_WIDTH  response byte.
- TX_D_VLD  out  1  response push to TX FIFO.
- BUSY  out  1  high in any state other than IDLE.

Function
REQ-004 SHALL register all outputs; strobes (WrEn, RdEn, ALU_EN, TX_D_VLD) SHALL be one-cycle pulses.
REQ-005 SHALL implement these FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI.
REQ-006 IDLE, on RX_D_VLD, SHALL go to WR_ADDR (0xAA), RD_ADDR (0xBB), OPA (0xCC) or FUN (0xDD); any other byte SHALL be dropped, staying in IDLE.
REQ-007 WR_ADDR SHALL latch RX_P_DATA[ADDR_WIDTH-1:0] as Address; upper bits SHALL be ignored.
REQ-008 WR_DATA, on RX_D_VLD, SHALL assert WrEn with WrData=RX_P_DATA on the next cycle and return to IDLE.
REQ-009 RD_ADDR, on RX_D_VLD, SHALL assert RdEn with the latched address on the next cycle and go to RD_WAIT.
REQ-010 RD_WAIT, on RdData_Valid, SHALL capture RdData and go to TX_LO.
REQ-011 OPA/OPB, on RX_D_VLD, SHALL write the byte to address 0 (OPA) or address 1 (OPB) via a WrEn pulse, then advance to OPB or FUN respectively.
REQ-012 FUN, on RX_D_VLD, SHALL set ALU_FUN=RX_P_DATA[3:0], set CLK_GATE_EN, pulse ALU_EN one cycle later, and go to ALU_WAIT.
REQ-013 ALU_WAIT, on ALU_OUT_VLD, SHALL capture ALU_OUT, clear CLK_GATE_EN, and go to TX_LO.
REQ-014 TX_LO SHALL pulse TX_D_VLD with the captured low byte only when FIFO_FULL=0, otherwise SHALL hold; after the push it SHALL go to TX_HI (ALU result with macro, REQ-019) or IDLE.
REQ-015 TX_HI SHALL push the high byte under the same FIFO_FULL rule, then go to IDLE.
REQ-016 RX_D_VLD arriving in RD_WAIT, ALU_WAIT, TX_LO or TX_HI SHALL be ignored.

Reset
REQ-017 On RST low, the FSM SHALL be forced to IDLE asynchronously, including mid-operation, and all outputs and captured data SHALL be cleared to 0.

Configuration
REQ-018 SHALL use the macro ALU_WIDE_RESULT_EN.
REQ-019 With ALU_WIDE_RESULT_EN defined, an ALU response SHALL be two TX bytes, low byte then high byte.
REQ-020 Without ALU_WIDE_RESULT_EN, an ALU response SHALL be the low byte only, and TX_HI SHALL be unreachable.
REQ-021 RF read responses SHALL be one byte in both builds.

Verification
REQ-022 RX bytes AA,04,12 -> one WrEn pulse with Address=4 and WrData=0x12; BUSY low afterwards.
REQ-023 RX bytes BB,04, then RdData=0x12 with RdData_Valid -> RdEn pulse with Address=4, then one TX_D_VLD with TX_P_DATA=0x12.
REQ-024 RX bytes CC,56,34,00, then ALU_OUT=0x008A -> writes addr0=0x56 and addr1=0x34, ALU_FUN=0, ALU_EN pulse; TX bytes: 0x8A, plus 0x00 when the macro is defined.
REQ-025 RX bytes DD,03 with FIFO_FULL held high for 20 cycles after ALU_OUT_VLD -> no TX_D_VLD until FIFO_FULL falls, then the push.
REQ-026 RX byte 0x77 -> no strobes, stays IDLE.
REQ-027 RST pulsed low in ALU_WAIT -> IDLE, CLK_GATE_EN=0, no TX pulse afterwards.

Source files
------------

// File: rtl/uart_cmd_scheduler.sv
// UART command scheduler: decodes RX frames into RF writes/reads and ALU ops.
// Optional macro ALU_WIDE_RESULT_EN: ALU responses send low then high byte.
module uart_cmd_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    BUSY
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] OPA      = 4'd5;
  localparam logic [3:0] OPB      = 4'd6;
  localparam logic [3:0] FUN      = 4'd7;
  localparam logic [3:0] ALU_WAIT = 4'd8;
  localparam logic [3:0] TX_LO    = 4'd9;
  localparam logic [3:0] TX_HI    = 4'd10;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  logic [3:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic                    wren_q, wren_d;
  logic                    rden_q, rden_d;
  logic                    alu_en_q, alu_en_d;
  logic [3:0]              fun_q, fun_d;
  logic                    cg_q, cg_d;
  logic [DATA_WIDTH-1:0]   txd_q, txd_d;
  logic                    txv_q, txv_d;
  logic                    busy_q, busy_d;
  logic                    go_q, go_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
`ifdef ALU_WIDE_RESULT_EN
  logic                    wide_q, wide_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    fun_d    = fun_q;
    cg_d     = cg_q;
    txd_d    = txd_q;
    go_d     = go_q;
    res_d    = res_q;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    alu_en_d = 1'b0;
    txv_d    = 1'b0;
`ifdef ALU_WIDE_RESULT_EN
    wide_d   = wide_q;
`endif
    unique case (state_q)
      IDLE: if (RX_D_VLD) begin
        if (RX_P_DATA == CMD_WR)       state_d = WR_ADDR;
        else if (RX_P_DATA == CMD_RD)  state_d = RD_ADDR;
        else if (RX_P_DATA == CMD_ALU) state_d = OPA;
        else if (RX_P_DATA == CMD_FUN) state_d = FUN;
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wdat_d  = RX_P_DATA;
        wren_d  = 1'b1;
        state_d = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        rden_d  = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (RdData_Valid) begin
        res_d   = {{DATA_WIDTH{1'b0}}, RdData};
        state_d = TX_LO;
`ifdef ALU_WIDE_RESULT_EN
        wide_d  = 1'b0;
`endif
      end
      OPA: if (RX_D_VLD) begin
        addr_d  = '0;
        wdat_d  = RX_P_DATA;
        wren_d  = 1'b1;
        state_d = OPB;
      end
      OPB: if (RX_D_VLD) begin
        addr_d  = ADDR_WIDTH'(1);
        wdat_d  = RX_P_DATA;
        wren_d  = 1'b1;
        state_d = FUN;
      end
      FUN: if (RX_D_VLD) begin
        fun_d   = RX_P_DATA[3:0];
        cg_d    = 1'b1;
        go_d    = 1'b1;
        state_d = ALU_WAIT;
      end
      // ALU_EN lags the gate enable by one cycle so the ALU clock is running
      ALU_WAIT: if (go_q) begin
        alu_en_d = 1'b1;
        go_d     = 1'b0;
      end else if (ALU_OUT_VLD) begin
        res_d   = ALU_OUT;
        cg_d    = 1'b0;
        state_d = TX_LO;
`ifdef ALU_WIDE_RESULT_EN
        wide_d  = 1'b1;
`endif
      end
      TX_LO: if (!FIFO_FULL) begin
        txd_d   = res_q[DATA_WIDTH-1:0];
        txv_d   = 1'b1;
`ifdef ALU_WIDE_RESULT_EN
        state_d = wide_q ? TX_HI : IDLE;
`else
        state_d = IDLE;
`endif
      end
      TX_HI: if (!FIFO_FULL) begin
        txd_d   = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        txv_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdat_q   <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      alu_en_q <= 1'b0;
      fun_q    <= '0;
      cg_q     <= 1'b0;
      txd_q    <= '0;
      txv_q    <= 1'b0;
      busy_q   <= 1'b0;
      go_q     <= 1'b0;
      res_q    <= '0;
`ifdef ALU_WIDE_RESULT_EN
      wide_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      alu_en_q <= alu_en_d;
      fun_q    <= fun_d;
      cg_q     <= cg_d;
      txd_q    <= txd_d;
      txv_q    <= txv_d;
      busy_q   <= busy_d;
      go_q     <= go_d;
      res_q    <= res_d;
`ifdef ALU_WIDE_RESULT_EN
      wide_q   <= wide_d;
`endif
    end
  end

  assign WrEn        = wren_q;
  assign RdEn        = rden_q;
  assign Address     = addr_q;
  assign WrData      = wdat_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = fun_q;
  assign CLK_GATE_EN = cg_q;
  assign TX_P_DATA   = txd_q;
  assign TX_D_VLD    = txv_q;
  assign BUSY        = busy_q;

endmodule
